alu_seq_unit: RTL

//  Registered, parametrised ALU for the Simple-RISC datapath, successor to the combinational 8-bit ALU.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_seq_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encoding, flag indices.
package alu_pkg;

    // Legacy opcodes 0-7, extended opcodes 8-11; 12-15 are illegal
    localparam int unsigned OP_HLT = 0;
    localparam int unsigned OP_SKZ = 1;
    localparam int unsigned OP_ADD = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_LDA = 5;
    localparam int unsigned OP_STO = 6;
    localparam int unsigned OP_JMP = 7;
    localparam int unsigned OP_SUB = 8;
    localparam int unsigned OP_MUL = 9;
    localparam int unsigned OP_SHL = 10;
    localparam int unsigned OP_SHR = 11;

    // FSM state encoding
    localparam int unsigned ST_W        = 1;
    localparam logic [0:0]  ST_IDLE     = 1'b0;
    localparam logic [0:0]  ST_MUL_BUSY = 1'b1;

    // Bit positions inside the registered flag vector
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_CARRY = 1;
    localparam int unsigned FLG_NEG   = 2;
    localparam int unsigned FLG_OVF   = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: WIDTH partial-product steps, done pulses with prod valid.
// The first step is folded into the start edge so done registers WIDTH-1 edges later,
// letting the parent register the product exactly WIDTH edges after start.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;

    // Load on start, then accumulate one shifted multiplicand per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                prod   <= b[0] ? PW'(a) : '0;
                mcand  <= PW'(a) << 1;
                mplier <= b >> 1;
                cnt    <= CW'(WIDTH - 1);
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    prod <= prod + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered Simple-RISC ALU with valid/ready input and a multi-cycle MUL.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned OPW    = 4,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             is_zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [ST_W-1:0]    state, state_nxt;
    logic               ready_nxt;
    logic               out_valid_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic [FLAG_W-1:0]  flags, flags_nxt;

    logic [WIDTH:0]     sum_w, diff_w, shl_w, shr_w;
    logic [SW-1:0]      amt;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_v;
    logic               is_mul;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign amt    = inB[SW-1:0];
    assign sum_w  = {1'b0, inA} + {1'b0, inB};
    assign diff_w = {1'b0, inA} - {1'b0, inB};
    assign shl_w  = {1'b0, inA} << amt;
    assign shr_w  = {inA, 1'b0} >> amt;
    assign is_mul = (opcode == OPW'(OP_MUL));

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (inA),
        .b     (inB),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Single-cycle operation mux; MUL (when enabled) and illegal codes fall to zero here
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (opcode)
            OPW'(OP_HLT), OPW'(OP_SKZ), OPW'(OP_STO), OPW'(OP_JMP): op_res = inA;
            OPW'(OP_LDA): op_res = inB;
            OPW'(OP_AND): op_res = inA & inB;
            OPW'(OP_XOR): op_res = inA ^ inB;
            OPW'(OP_ADD): begin
                op_res = sum_w[WIDTH-1:0];
                op_c   = sum_w[WIDTH];
                op_v   = (inA[WIDTH-1] == inB[WIDTH-1]) && (sum_w[WIDTH-1] != inA[WIDTH-1]);
            end
            OPW'(OP_SUB): begin
                op_res = diff_w[WIDTH-1:0];
                op_c   = diff_w[WIDTH];
                op_v   = (inA[WIDTH-1] != inB[WIDTH-1]) && (diff_w[WIDTH-1] != inA[WIDTH-1]);
            end
            OPW'(OP_SHL): begin
                op_res = shl_w[WIDTH-1:0];
                op_c   = shl_w[WIDTH];
            end
            OPW'(OP_SHR): begin
                op_res = shr_w[WIDTH:1];
                op_c   = shr_w[0];
            end
            default: begin
                op_res = '0;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = 1'b0;
        result_nxt    = result;
        flags_nxt     = flags;
        mul_start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (MUL_EN && is_mul) begin
                        mul_start = 1'b1;
                        state_nxt = ST_MUL_BUSY;
                    end else begin
                        out_valid_nxt        = 1'b1;
                        result_nxt           = op_res;
                        flags_nxt[FLG_ZERO]  = (op_res == '0);
                        flags_nxt[FLG_CARRY] = op_c;
                        flags_nxt[FLG_NEG]   = op_res[WIDTH-1];
                        flags_nxt[FLG_OVF]   = op_v;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    state_nxt            = ST_IDLE;
                    out_valid_nxt        = 1'b1;
                    result_nxt           = mul_prod[WIDTH-1:0];
                    flags_nxt[FLG_ZERO]  = (mul_prod[WIDTH-1:0] == '0);
                    flags_nxt[FLG_CARRY] = |mul_prod[2*WIDTH-1:WIDTH];
                    flags_nxt[FLG_NEG]   = mul_prod[WIDTH-1];
                    flags_nxt[FLG_OVF]   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready_nxt = (state_nxt == ST_IDLE);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            result          <= '0;
            flags           <= '0;
            flags[FLG_ZERO] <= 1'b1;
        end else begin
            state     <= state_nxt;
            in_ready  <= ready_nxt;
            out_valid <= out_valid_nxt;
            result    <= result_nxt;
            flags     <= flags_nxt;
        end
    end

    assign is_zero  = flags[FLG_ZERO];
    assign carry    = flags[FLG_CARRY];
    assign negative = flags[FLG_NEG];
    assign overflow = flags[FLG_OVF];

endmodule
